d5m_frame_tx: RTL and testbench
===============================

D5M_FRAME_TX -- requirements
Module: d5m_frame_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line (2..4095).
REQ-002 SHALL have parameter H_BLANK, default 160: pixel ticks per line with o_lval low and o_fval high (1..4095).
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame (1..4095).
REQ-004 SHALL have parameter V_BLANK, default 1000: pixel ticks between frames with o_fval low (1..65535).
REQ-005 SHALL have port i_clk  in  1: single clock; all logic rises on this edge.
REQ-006 SHALL have port i_rst_n  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_tick  in  1: pixel-advance enable; the block advances one pixel position only on i_clk edges where i_tick=1.
REQ-008 SHALL have port i_enable  in  1: run request; frames are generated back-to-back while it is high.
REQ-009 SHALL have port i_mode  in  2: pattern select, sampled at frame start.
REQ-010 SHALL have port o_fval  out  1: frame valid, D5M FVAL-compatible.
REQ-011 SHALL have port o_lval  out  1: line valid, D5M LVAL-compatible.
REQ-012 SHALL have port o_data  out  12: pixel data, D5M D[11:0]-compatible.
REQ-013 SHALL have port o_busy  out  1: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port o_frame_done  out  1: one-i_clk pulse when o_fval falls.
REQ-015 SHALL have port o_frame_cnt  out  16: number of completed frames.

Function
REQ-016 SHALL implement FSM states IDLE, LINE, HBLANK and VBLANK, with column counter col and row counter row; all outputs are registered.
REQ-017 SHALL leave every state, counter and output unchanged on any i_clk edge with i_tick=0.
REQ-018 SHALL go IDLE->LINE on a tick with i_enable=1, and on that edge load col=0, row=0, latch i_mode, and set o_fval=1 and o_lval=1.
REQ-019 SHALL stay in LINE for H_ACTIVE ticks, with col=0..H_ACTIVE-1 and o_lval=1, then enter HBLANK with o_lval=0 and o_fval=1.
REQ-020 SHALL stay in HBLANK for H_BLANK ticks; if row<V_ACTIVE-1 it then returns to LINE with row+1 and col=0, otherwise it enters VBLANK with o_fval=0.
REQ-021 SHALL stay in VBLANK for V_BLANK ticks, then enter LINE (new frame, mode re-latched) if i_enable=1, otherwise IDLE.
REQ-022 SHALL produce a frame of exactly V_ACTIVE*(H_ACTIVE+H_BLANK)+V_BLANK ticks from LINE entry to the end of VBLANK.
REQ-023 SHALL drive o_data as a function of the latched mode while o_lval=1: mode0 = col[11:0]; mode1 = row[11:0]; mode2 = 12'hFFF if col[3]^row[3], else 12'h000; mode3 = o_frame_cnt[11:0].
REQ-024 SHALL drive o_data=12'h000 whenever o_lval=0.
REQ-025 SHALL assert o_frame_done for exactly one i_clk cycle, on the cycle o_fval goes 1->0, and increment o_frame_cnt on that same edge, wrapping modulo 2^16 (16'hFFFF->16'h0000).
REQ-026 SHALL always complete the current frame, including VBLANK, when i_enable falls mid-frame; frames are never truncated.
REQ-027 SHALL ignore i_mode changes within a frame.
REQ-028 SHALL never assert o_lval=1 while o_fval=0.

Reset
REQ-029 SHALL, on i_rst_n=0 (asynchronous, including mid-frame), force IDLE, col=0, row=0, latched mode=0, o_fval=0, o_lval=0, o_data=0, o_busy=0, o_frame_done=0 and o_frame_cnt=0.
REQ-030 SHALL start no frame until i_rst_n=1 and a tick with i_enable=1 has occurred.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=5)
REQ-031 SHALL cover: i_tick=1 constantly, mode0, i_enable pulsed for one tick -> exactly one frame; o_fval high 18 ticks; three o_lval bursts of 4; o_data 0,1,2,3 per line; o_frame_done pulses once; o_frame_cnt=1; IDLE after 23 ticks.
REQ-032 SHALL cover: i_enable held high, mode1, 3 frames -> o_data 0,0,0,0 / 1,1,1,1 / 2,2,2,2 per frame; the next o_fval rise occurs exactly 5 ticks after each fall; o_frame_cnt=3.
REQ-033 SHALL cover: i_tick toggling 1,0,1,0 -> o_lval burst lasts 8 i_clk cycles with each o_data value held 2 cycles; total frame length is 46 cycles.
REQ-034 SHALL cover: i_mode changed from 0 to 2 mid-frame -> the current frame keeps ramp data; the next frame's data is 12'h000 (H_ACTIVE=4 keeps col[3]=0 on row 0).
REQ-035 SHALL cover: i_rst_n pulsed low during row 1 -> all outputs are 0 immediately, without waiting for an i_clk edge; o_frame_cnt=0; the block stays IDLE until i_enable is high.
REQ-036 SHALL cover: o_frame_cnt forced to 16'hFFFF, one frame run -> o_frame_cnt wraps to 16'h0000 and o_frame_done pulses once.

Source files
------------

// File: rtl/d5m_frame_tx.sv
// D5M-style frame generator: FVAL/LVAL timing plus test patterns.
// Advances one pixel position per i_tick; all outputs registered.
module d5m_frame_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  output logic        o_fval,
  output logic        o_lval,
  output logic [11:0] o_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_LINE, S_HBLANK, S_VBLANK
  } state_t;

  localparam logic [11:0] COL_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] ROW_LAST = 12'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);

  state_t      r_state, w_next;
  logic [11:0] r_col, r_row, w_col, w_row;
  logic [15:0] r_bcnt, w_bcnt;
  logic [1:0]  r_mode, w_mode;
  logic        r_fval, r_lval, r_busy, r_done;
  logic [11:0] r_data;
  logic [15:0] r_frame_cnt;
  logic        w_fval, w_lval, w_done;
  logic [11:0] w_data;
  logic        w_line_end, w_hb_end, w_vb_end, w_last_row;

  assign w_line_end = (r_col == COL_LAST);
  assign w_hb_end   = (r_bcnt == HB_LAST);
  assign w_vb_end   = (r_bcnt == VB_LAST);
  assign w_last_row = (r_row == ROW_LAST);

  // State register: moves only on ticks
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else if (i_tick) r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (i_tick) begin
      unique case (r_state)
        S_IDLE:   if (i_enable) w_next = S_LINE;
        S_LINE:   if (w_line_end) w_next = S_HBLANK;
        S_HBLANK: if (w_hb_end)
                    w_next = w_last_row ? S_VBLANK : S_LINE;
        S_VBLANK: if (w_vb_end)
                    w_next = i_enable ? S_LINE : S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Counter and latched-mode next values
  always_comb begin
    w_col  = r_col;
    w_row  = r_row;
    w_bcnt = r_bcnt;
    w_mode = r_mode;
    if (i_tick) begin
      unique case (r_state)
        S_IDLE: if (i_enable) begin
          w_col  = '0;
          w_row  = '0;
          w_mode = i_mode;
        end
        S_LINE: begin
          if (w_line_end) w_bcnt = '0;
          else w_col = r_col + 12'd1;
        end
        S_HBLANK: begin
          if (!w_hb_end) w_bcnt = r_bcnt + 16'd1;
          else if (w_last_row) w_bcnt = '0;
          else begin
            w_row = r_row + 12'd1;
            w_col = '0;
          end
        end
        S_VBLANK: begin
          if (!w_vb_end) w_bcnt = r_bcnt + 16'd1;
          else begin
            w_col  = '0;
            w_row  = '0;
            w_mode = i_mode;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: values the output registers take next
  always_comb begin
    w_fval = (w_next == S_LINE) || (w_next == S_HBLANK);
    w_lval = (w_next == S_LINE);
    w_done = i_tick && (r_state == S_HBLANK) &&
             w_hb_end && w_last_row;
    w_data = '0;
    if (w_lval) begin
      unique case (w_mode)
        2'd0: w_data = w_col;
        2'd1: w_data = w_row;
        2'd2: w_data = (w_col[3] ^ w_row[3]) ? 12'hFFF : 12'h000;
        default: w_data = r_frame_cnt[11:0];
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_bcnt      <= '0;
      r_mode      <= '0;
      r_fval      <= 1'b0;
      r_lval      <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= w_done;
      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (i_tick) begin
        r_col  <= w_col;
        r_row  <= w_row;
        r_bcnt <= w_bcnt;
        r_mode <= w_mode;
        r_fval <= w_fval;
        r_lval <= w_lval;
        r_data <= w_data;
        r_busy <= (w_next != S_IDLE);
      end
    end
  end

  assign o_fval       = r_fval;
  assign o_lval       = r_lval;
  assign o_data       = r_data;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_d5m_frame_tx.sv
// Bench for d5m_frame_tx: frame-position reference model,
// directed scenarios and a randomized tail.
module tb_d5m_frame_tx;

  localparam int HA  = 4;
  localparam int HB  = 2;
  localparam int VA  = 3;
  localparam int VB  = 5;
  localparam int LW  = HA + HB;
  localparam int FV  = VA * LW;
  localparam int LEN = FV + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        fval, lval, busy, done;
  logic [11:0] data;
  logic [15:0] fcnt;

  d5m_frame_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
    .i_enable(en), .i_mode(mode),
    .o_fval(fval), .o_lval(lval), .o_data(data),
    .o_busy(busy), .o_frame_done(done), .o_frame_cnt(fcnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: position within the frame, in ticks
  bit          m_run;
  int          m_pos;
  logic [1:0]  m_mode;
  logic [15:0] m_cnt;
  bit          m_done;

  task automatic m_reset();
    m_run = 0; m_pos = 0; m_mode = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic m_clock();
    m_done = 0;
    if (!rst_n) m_reset();
    else if (tick) begin
      if (!m_run) begin
        if (en) begin m_run = 1; m_pos = 0; m_mode = mode; end
      end else begin
        m_pos++;
        if (m_pos == FV) begin m_done = 1; m_cnt++; end
        if (m_pos == LEN) begin
          if (en) begin m_pos = 0; m_mode = mode; end
          else m_run = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit fv, lv;
    int r, c;
    logic [11:0] d, cv, rv;
    fv = m_run && (m_pos < FV);
    r  = m_pos / LW;
    c  = m_pos % LW;
    lv = fv && (c < HA);
    cv = 12'(c);
    rv = 12'(r);
    d  = 12'h000;
    if (lv) begin
      case (m_mode)
        2'd0: d = cv;
        2'd1: d = rv;
        2'd2: d = (cv[3] ^ rv[3]) ? 12'hFFF : 12'h000;
        default: d = m_cnt[11:0];
      endcase
    end
    chk({tag, ".fval"}, 32'(fval), 32'(fv));
    chk({tag, ".lval"}, 32'(lval), 32'(lv));
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".cnt"},  32'(fcnt), 32'(m_cnt));
    chk({tag, ".lv_fv"}, 32'(lval & ~fval), 32'd0);
  endtask

  // Observed-behaviour statistics for scenario checks
  int s_fv, s_lv, s_lrise, s_done, s_busy, s_gap;
  logic s_plv;

  task automatic clr_stats();
    s_fv = 0; s_lv = 0; s_lrise = 0;
    s_done = 0; s_busy = 0; s_gap = 0; s_plv = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_clock();
    #1;
    check_all(tag);
    if (fval) s_fv++;
    if (lval) s_lv++;
    if (lval && !s_plv) s_lrise++;
    s_plv = lval;
    if (done) s_done++;
    if (busy) s_busy++;
    if (busy && !fval) s_gap++;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    step("rst");
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int n, input int budget,
                           input string tag);
    int k = 0;
    while (s_done < n && k < budget) begin
      step(tag);
      k++;
    end
    chk({tag, ".timeout"}, 32'(s_done >= n), 32'd1);
  endtask

  initial begin
    m_reset();
    clr_stats();
    // reset state
    repeat (3) step("reset");
    rst_n = 1'b1;
    tick = 1'b1;
    repeat (4) step("idle_noen");

    // single one-tick enable pulse, ramp pattern
    clr_stats();
    mode = 2'd0; en = 1'b1;
    step("one");
    en = 1'b0;
    repeat (30) step("one");
    chk("one.fval_ticks", s_fv, FV);
    chk("one.lval_bursts", s_lrise, VA);
    chk("one.lval_ticks", s_lv, VA * HA);
    chk("one.done_pulses", s_done, 1);
    chk("one.busy_ticks", s_busy, LEN);
    chk("one.cnt", 32'(fcnt), 32'd1);

    // back-to-back frames, row pattern
    sync_reset();
    clr_stats();
    mode = 2'd1; en = 1'b1;
    wait_done(3, 200, "b2b");
    en = 1'b0;
    repeat (30) step("b2b");
    chk("b2b.done_pulses", s_done, 3);
    chk("b2b.gap_ticks", s_gap, 3 * VB);
    chk("b2b.cnt", 32'(fcnt), 32'd3);

    // tick on every other clock
    sync_reset();
    clr_stats();
    mode = 2'd0; tick = 1'b1; en = 1'b1;
    step("half");
    en = 1'b0;
    for (int i = 0; i < 2 * LEN + 10; i++) begin
      tick = ~tick;
      step("half");
    end
    chk("half.busy_cycles", s_busy, 2 * LEN);
    chk("half.lval_cycles", s_lv, 2 * VA * HA);
    chk("half.done_pulses", s_done, 1);
    tick = 1'b1;

    // mode change mid-frame
    sync_reset();
    clr_stats();
    mode = 2'd0; en = 1'b1;
    repeat (8) step("mode");
    mode = 2'd2;
    wait_done(2, 100, "mode");
    en = 1'b0;
    repeat (10) step("mode");
    chk("mode.cnt", 32'(fcnt), 32'd2);

    // asynchronous reset during row 1
    sync_reset();
    clr_stats();
    mode = 2'd3; en = 1'b1;
    repeat (8) step("arst");
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("arst_now");
    en = 1'b0;
    step("arst_hold");
    rst_n = 1'b1;
    repeat (5) step("arst_idle");
    en = 1'b1;
    step("arst_go");
    en = 1'b0;
    repeat (LEN + 2) step("arst_go");

    // frame counter wrap
    sync_reset();
    clr_stats();
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    #1 release dut.r_frame_cnt;
    m_cnt = 16'hFFFF;
    #1;
    chk("wrap.preset", 32'(fcnt), 32'hFFFF);
    mode = 2'd3; en = 1'b1;
    step("wrap");
    en = 1'b0;
    repeat (LEN + 3) step("wrap");
    chk("wrap.cnt", 32'(fcnt), 32'h0000);
    chk("wrap.done_pulses", s_done, 1);

    // randomized stimulus
    sync_reset();
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) en = ~en;
      mode = 2'($urandom_range(3));
      if ($urandom_range(499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
